// File: rtl/branch_predict_if.sv
// branch_predict_if: fetch lookup, EX resolve/train and statistics signals of branch_predict_unit
// master drives lookups, resolved-branch info and stat_clear; slave returns prediction, outcome, flush and counts
interface branch_predict_if #(
    parameter int PC_WIDTH    = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   if_valid;
    logic [PC_WIDTH-1:0]    if_pc;
    logic                   predict_taken;
    logic                   ex_valid;
    logic [2:0]             ex_branch;
    logic                   ex_zero;
    logic                   ex_sign;
    logic [PC_WIDTH-1:0]    ex_pc;
    logic                   ex_predicted;
    logic                   taken;
    logic                   mispredict;
    logic                   flush;
    logic                   stat_clear;
    logic [COUNT_WIDTH-1:0] branch_count;
    logic [COUNT_WIDTH-1:0] miss_count;
    modport master (
        output if_valid, if_pc, ex_valid, ex_branch, ex_zero, ex_sign, ex_pc, ex_predicted, stat_clear,
        input  predict_taken, taken, mispredict, flush, branch_count, miss_count
    );
    modport slave (
        input  if_valid, if_pc, ex_valid, ex_branch, ex_zero, ex_sign, ex_pc, ex_predicted, stat_clear,
        output predict_taken, taken, mispredict, flush, branch_count, miss_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves MIPS conditional branches in EX, flags mispredicts and trains a 2-bit counter table for IF
// ports: clock, reset (async, active-high), bus (branch_predict_if.slave: lookup, resolve, flush, statistics)
module branch_predict_unit #(
    parameter int         PC_WIDTH    = 32,
    parameter int         INDEX_BITS  = 6,
    parameter logic [1:0] INIT_STATE  = 2'b01,
    parameter int         COUNT_WIDTH = 16
) (
    input logic             clock,
    input logic             reset,
    branch_predict_if.slave bus
);
    localparam int ENTRIES = 2 ** INDEX_BITS;
    logic [1:0]             pht [ENTRIES];
    logic [INDEX_BITS-1:0]  if_idx, ex_idx;
    logic                   is_branch, cond;
    logic [1:0]             cur, nxt;
    logic [COUNT_WIDTH-1:0] branch_q, miss_q;
    logic                   flush_q;
    assign if_idx    = bus.if_pc[INDEX_BITS+1:2];
    assign ex_idx    = bus.ex_pc[INDEX_BITS+1:2];
    assign is_branch = bus.ex_valid & (bus.ex_branch != 3'b000) & (bus.ex_branch != 3'b010);
    always_comb begin
        cond = bus.ex_branch == 3'b001 ? !bus.ex_zero :
               bus.ex_branch == 3'b011 ? bus.ex_zero :
               bus.ex_branch == 3'b100 ? bus.ex_sign | bus.ex_zero :
               bus.ex_branch == 3'b101 ? !bus.ex_sign & !bus.ex_zero :
               bus.ex_branch == 3'b110 ? bus.ex_sign :
               bus.ex_branch == 3'b111 ? !bus.ex_sign : 1'b0;
        cur  = pht[ex_idx];
        nxt  = bus.taken ? (cur == 2'b11 ? cur : cur + 2'd1) : (cur == 2'b00 ? cur : cur - 2'd1);
    end
    assign bus.taken         = is_branch & cond;
    assign bus.mispredict    = is_branch & (bus.taken != bus.ex_predicted);
    assign bus.predict_taken = bus.if_valid & pht[if_idx][1];
    assign bus.flush         = flush_q;
    assign bus.branch_count  = branch_q;
    assign bus.miss_count    = miss_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= INIT_STATE;
        end else if (is_branch) begin
            pht[ex_idx] <= nxt;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_q  <= 1'b0;
            branch_q <= '0;
            miss_q   <= '0;
        end else begin
            flush_q  <= bus.mispredict;
            branch_q <= bus.stat_clear ? '0 : (is_branch && !(&branch_q)) ? branch_q + 1'b1 : branch_q;
            miss_q   <= bus.stat_clear ? '0 : (bus.mispredict && !(&miss_q)) ? miss_q + 1'b1 : miss_q;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed checks of prediction, resolution, training, saturation, statistics and reset
module tb_branch_predict_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    always #5 clock = ~clock;
    branch_predict_if #(.PC_WIDTH(32), .COUNT_WIDTH(16)) b1 ();
    branch_predict_if #(.PC_WIDTH(32), .COUNT_WIDTH(4))  b2 ();
    branch_predict_unit #(.PC_WIDTH(32), .INDEX_BITS(6), .INIT_STATE(2'b01), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .bus(b1.slave)
    );
    branch_predict_unit #(.PC_WIDTH(32), .INDEX_BITS(6), .INIT_STATE(2'b01), .COUNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .bus(b2.slave)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic ex1(input logic v, input logic [2:0] br, input logic z, input logic s,
                       input logic [31:0] pc, input logic pred);
        b1.ex_valid = v; b1.ex_branch = br; b1.ex_zero = z; b1.ex_sign = s;
        b1.ex_pc = pc; b1.ex_predicted = pred;
    endtask
    logic [3:0] tt [8] = '{4'b0000, 4'b0011, 4'b0000, 4'b1100, 4'b1110, 4'b0001, 4'b1010, 4'b0101};
    initial begin
        b1.if_valid = 0; b1.if_pc = 0; b1.stat_clear = 0; ex1(0, 3'b000, 0, 0, 0, 0);
        b2.if_valid = 0; b2.if_pc = 0; b2.stat_clear = 0;
        b2.ex_valid = 0; b2.ex_branch = 0; b2.ex_zero = 0; b2.ex_sign = 0; b2.ex_pc = 0; b2.ex_predicted = 0;
        tick(); tick();
        chk("rst_flush", b1.flush, 0);
        chk("rst_bcnt", b1.branch_count, 0);
        reset = 0;
        b1.if_valid = 1; b1.if_pc = 32'h40;
        #1;
        chk("init_pred40", b1.predict_taken, 0);
        chk("init_bcnt", b1.branch_count, 0);
        chk("init_mcnt", b1.miss_count, 0);
        chk("init_flush", b1.flush, 0);
        b1.if_valid = 0;
        #1;
        chk("pred_invalid", b1.predict_taken, 0);
        b1.if_valid = 1;
        // BEQ taken twice, predicted not-taken
        ex1(1, 3'b011, 1, 0, 32'h40, 0);
        #1;
        chk("beq1_taken", b1.taken, 1);
        chk("beq1_misp", b1.mispredict, 1);
        chk("beq1_pred", b1.predict_taken, 0);
        tick();
        chk("beq2_taken", b1.taken, 1);
        chk("beq2_misp", b1.mispredict, 1);
        chk("beq2_pred", b1.predict_taken, 1);
        chk("beq2_flush", b1.flush, 1);
        tick();
        ex1(0, 3'b011, 1, 0, 32'h40, 0);
        #1;
        chk("beq3_flush", b1.flush, 1);
        chk("beq3_mcnt", b1.miss_count, 2);
        chk("beq3_bcnt", b1.branch_count, 2);
        chk("beq3_pred", b1.predict_taken, 1);
        chk("beq3_taken_inv", b1.taken, 0);
        tick();
        chk("beq4_flush", b1.flush, 0);
        // non-branch codes and invalid slot leave table (entry 0 = 01) and counts alone
        b1.if_pc = 32'h0;
        ex1(1, 3'b000, 1, 0, 32'h0, 1);
        #1;
        chk("code000_misp", b1.mispredict, 0);
        tick();
        ex1(1, 3'b010, 1, 0, 32'h0, 1);
        #1;
        chk("code010_taken", b1.taken, 0);
        tick();
        ex1(0, 3'b011, 1, 0, 32'h0, 0);
        tick();
        chk("nb_pred0", b1.predict_taken, 0);
        chk("nb_bcnt", b1.branch_count, 2);
        chk("nb_mcnt", b1.miss_count, 2);
        // all codes x {zero,sign} on the narrow-counter instance
        for (int c = 0; c < 8; c++) begin
            for (int zs = 0; zs < 4; zs++) begin
                logic [3:0] row;
                logic [1:0] zsv;
                row = tt[c];
                zsv = 2'(zs);
                b2.ex_valid = 1; b2.ex_branch = 3'(c); b2.ex_zero = zsv[1]; b2.ex_sign = zsv[0];
                b2.ex_predicted = 0;
                #1;
                chk($sformatf("type%0d_zs%0d_taken", c, zs), b2.taken, row[zs]);
                chk($sformatf("type%0d_zs%0d_misp", c, zs), b2.mispredict, row[zs]);
                tick();
            end
        end
        b2.ex_valid = 0;
        #1;
        chk("w4_bcnt_sat24", b2.branch_count, 15);
        b2.ex_valid = 1; b2.ex_branch = 3'b011; b2.ex_zero = 1;
        for (int k = 0; k < 20; k++) tick();
        b2.ex_valid = 0;
        #1;
        chk("w4_bcnt_sat44", b2.branch_count, 15);
        chk("w4_mcnt_sat", b2.miss_count, 15);
        // counter saturation at index 3
        b1.if_pc = 32'hC;
        ex1(1, 3'b011, 1, 0, 32'hC, 1);
        for (int k = 0; k < 5; k++) tick();
        ex1(0, 3'b011, 1, 0, 32'hC, 1);
        #1;
        chk("sat_hi_pred", b1.predict_taken, 1);
        ex1(1, 3'b011, 0, 0, 32'hC, 1);
        tick();
        chk("sat_hi_dec1", b1.predict_taken, 1);
        for (int k = 0; k < 4; k++) tick();
        ex1(0, 3'b011, 0, 0, 32'hC, 1);
        #1;
        chk("sat_lo_pred", b1.predict_taken, 0);
        ex1(1, 3'b011, 1, 0, 32'hC, 1);
        tick();
        chk("sat_lo_inc1", b1.predict_taken, 0);
        tick();
        chk("sat_lo_inc2", b1.predict_taken, 1);
        ex1(0, 3'b011, 1, 0, 32'hC, 1);
        #1;
        chk("sat_bcnt", b1.branch_count, 14);
        chk("sat_mcnt", b1.miss_count, 7);
        // same-cycle lookup/update at 0x80, no bypass
        b1.if_pc = 32'h80;
        ex1(1, 3'b001, 0, 0, 32'h80, 0);
        #1;
        chk("same_taken", b1.taken, 1);
        chk("same_pred_pre", b1.predict_taken, 0);
        tick();
        ex1(0, 3'b001, 0, 0, 32'h80, 0);
        #1;
        chk("same_pred_post", b1.predict_taken, 1);
        chk("same_bcnt", b1.branch_count, 15);
        chk("same_mcnt", b1.miss_count, 8);
        // stat_clear wins over a coincident mispredict
        b1.stat_clear = 1;
        ex1(1, 3'b011, 1, 0, 32'h200, 0);
        tick();
        b1.stat_clear = 0;
        ex1(0, 3'b011, 1, 0, 32'h200, 0);
        #1;
        chk("clr_bcnt", b1.branch_count, 0);
        chk("clr_mcnt", b1.miss_count, 0);
        chk("clr_flush", b1.flush, 1);
        chk("clr_table_kept", b1.predict_taken, 1);
        // reset mid-stream with flush pending and trained entries
        b1.if_pc = 32'hC;
        ex1(1, 3'b011, 1, 0, 32'hC, 0);
        tick();
        chk("pre_rst_flush", b1.flush, 1);
        chk("pre_rst_pred", b1.predict_taken, 1);
        reset = 1;
        #1;
        chk("rst_mid_flush", b1.flush, 0);
        chk("rst_mid_pred", b1.predict_taken, 0);
        chk("rst_mid_bcnt", b1.branch_count, 0);
        chk("rst_mid_mcnt", b1.miss_count, 0);
        chk("rst_mid_taken", b1.taken, 1);
        tick();
        reset = 0;
        ex1(0, 3'b011, 1, 0, 32'hC, 0);
        #1;
        chk("post_rst_pred_c", b1.predict_taken, 0);
        b1.if_pc = 32'h40;
        #1;
        chk("post_rst_pred40", b1.predict_taken, 0);
        b1.if_pc = 32'h80;
        #1;
        chk("post_rst_pred80", b1.predict_taken, 0);
        chk("post_rst_flush", b1.flush, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the BEQ/BNE decision gate for the MIPS pipeline. It resolves six conditional branch types in EX, flags mispredictions against the prediction carried down the pipe, and trains a direct-mapped table of 2-bit saturating counters. That table supplies a taken/not-taken prediction to IF. It also keeps saturating branch and misprediction statistics counters.

## Interface
- PC_WIDTH, 32: width of PC buses.
- INDEX_BITS, 6: table index width; table has 2**INDEX_BITS entries, indexed by pc[INDEX_BITS+1:2].
- INIT_STATE, 2'b01: counter value loaded into every table entry at reset (weakly not-taken).
- COUNT_WIDTH, 16: width of each statistics counter.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- if_valid  in  1  fetch-stage lookup valid.
- if_pc  in  PC_WIDTH  PC being fetched.
- predict_taken  out  1  prediction for if_pc (combinational).
- ex_valid  in  1  EX-stage instruction valid (not bubble, not stalled).
- ex_branch  in  3  branch type: 000 none, 001 BNE, 011 BEQ, 100 BLEZ, 101 BGTZ, 110 BLTZ, 111 BGEZ, 010 reserved (treated as none).
- ex_zero  in  1  comparison-equal / rs==0 flag from ALU.
- ex_sign  in  1  sign bit of rs.
- ex_pc  in  PC_WIDTH  PC of the instruction in EX (table update index).
- ex_predicted  in  1  prediction issued for this instruction at IF.
- taken  out  1  resolved outcome (combinational).
- mispredict  out  1  resolved outcome differs from ex_predicted (combinational).
- flush  out  1  registered one-cycle copy of mispredict.
- stat_clear  in  1  synchronous clear of statistics counters.
- branch_count  out  COUNT_WIDTH  resolved branches seen.
- miss_count  out  COUNT_WIDTH  mispredictions seen.

## Operation
- is_branch = ex_valid & ex_branch ∉ {000, 010}.
- Conditions: BEQ = ex_zero; BNE = !ex_zero; BLEZ = ex_sign | ex_zero; BGTZ = !ex_sign & !ex_zero; BLTZ = ex_sign; BGEZ = !ex_sign.
- taken = is_branch & condition; 0 when not a branch.
- mispredict = is_branch & (taken != ex_predicted).
- predict_taken = if_valid & table[if_pc[INDEX_BITS+1:2]][1]. It is 0 when if_valid is low.
- Table update happens on each edge with is_branch. Entry ex_pc[INDEX_BITS+1:2] increments if taken and decrements otherwise. It saturates at 3 and at 0; there is no wrap-around.
- No update when is_branch = 0, including reserved code and ex_valid = 0.
- Statistics: branch_count increments on is_branch and miss_count increments on mispredict. Each counter saturates at all-ones.
- stat_clear has priority over increment. Clear and event in the same cycle gives 0.
- Table is not affected by stat_clear.

## Timing
- Reset (asynchronous, immediate): every table entry = INIT_STATE; flush = 0; branch_count = miss_count = 0. Combinational outputs follow inputs during reset.
- predict_taken, taken and mispredict have zero latency. flush asserts one cycle after mispredict.
- Table write is visible to lookups from the cycle after the edge.
- Same-index lookup and update in the same cycle: lookup returns the pre-update value. There is no bypass.
- Consecutive updates to one index apply one step per edge.
- Reset asserted mid-operation discards any pending update and any pending flush pulse.

## Test plan
- Reset, then look up if_pc=0x40 with if_valid=1 -> predict_taken=0 (entry 16 = 01). branch_count=0, miss_count=0, flush=0.
- BEQ at ex_pc=0x40 with ex_zero=1, ex_predicted=0, in two consecutive cycles -> taken=1, mispredict=1 each cycle, flush high in cycles 2 and 3. Entry 16 goes 01→10→11, so predict_taken for 0x40 = 1 after the first edge. miss_count=2.
- All six types, with all four {ex_zero, ex_sign} combinations, plus codes 000 and 010 -> taken matches the condition equations. Codes 000 and 010 give taken=0, no table change and no count.
- Saturation: five taken updates at index 3 -> entry stays 11. Five not-taken updates -> entry stays 00. Force counters near max with COUNT_WIDTH=4 and apply 20 branches -> branch_count holds at 15.
- Same-cycle if_pc = ex_pc = 0x80 with entry 01 and a taken BNE -> predict_taken=0 that cycle and 1 the next. stat_clear together with a mispredict -> both counts 0 the next cycle.
- Assert reset mid-stream, while flush is pending and the table is trained -> flush=0 immediately, all entries back to 01, counts 0.
